// File: rtl/rsa_modexp_decrypt.sv
// rtl/rsa_modexp_decrypt.sv - sequential RSA decryption m = c^d mod n using shift-add modular products
module rsa_modexp_decrypt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] n_in,
    input  logic [W-1:0] d_in,
    input  logic [W-1:0] c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] msg_out,
    output logic         err_out,
    output logic         busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] TOP = CW'(W - 1);

    typedef enum logic [2:0] {IDLE, REDUCE, MUL, UPDATE, DONE} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   n_r, d_r, c_r;
    logic [W-1:0]   res, base, p1, p2, msg_r;
    logic           err_r;
    logic [CW-1:0]  cnt, k;
    logic           accept, bad_n;
    logic [W-1:0]   a1, s1, s2;
    logic           b1;

    // One interleaved step: r <- (2r + bit*a) mod n, with a W+1 bit intermediate so n = 2^W-1 cannot overflow.
    function automatic logic [W-1:0] mm_step(input logic [W-1:0] r, input logic [W-1:0] a,
                                             input logic [W-1:0] n, input logic b_bit);
        logic [W:0] r2;
        logic [W:0] r3;
        r2 = {r, 1'b0};
        if (r2 >= {1'b0, n})
            r2 = r2 - {1'b0, n};
        r3 = r2;
        if (b_bit) begin
            r3 = r2 + {1'b0, a};
            if (r3 >= {1'b0, n})
                r3 = r3 - {1'b0, n};
        end
        return r3[W-1:0];
    endfunction

    assign accept = in_valid && (state == IDLE);
    assign bad_n  = (n_in < W'(2));

    // REDUCE reuses the P1 lane as 1*c mod n; MUL scans base bits for both products.
    assign a1 = (state == REDUCE) ? W'(1) : res;
    assign b1 = (state == REDUCE) ? c_r[cnt] : base[cnt];
    assign s1 = mm_step(p1, a1, n_r, b1);
    assign s2 = mm_step(p2, base, n_r, base[cnt]);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = bad_n ? DONE : REDUCE;
            REDUCE:  if (cnt == '0) state_nx = MUL;
            MUL:     if (cnt == '0) state_nx = UPDATE;
            UPDATE:  state_nx = (k == TOP) ? DONE : MUL;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_r   <= '0;
            d_r   <= '0;
            c_r   <= '0;
            res   <= '0;
            base  <= '0;
            p1    <= '0;
            p2    <= '0;
            cnt   <= '0;
            k     <= '0;
            msg_r <= '0;
            err_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        n_r <= n_in;
                        d_r <= d_in;
                        c_r <= c_in;
                        p1  <= '0;
                        cnt <= TOP;
                        k   <= '0;
                        if (bad_n) begin
                            msg_r <= '0;
                            err_r <= 1'b1;
                        end
                    end
                end
                REDUCE: begin
                    p1  <= s1;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        base <= s1;
                        res  <= W'(1);
                        p1   <= '0;
                        p2   <= '0;
                        cnt  <= TOP;
                    end
                end
                MUL: begin
                    p1  <= s1;
                    p2  <= s2;
                    cnt <= (cnt == '0) ? TOP : cnt - CW'(1);
                end
                UPDATE: begin
                    if (d_r[k])
                        res <= p1;
                    base <= p2;
                    p1   <= '0;
                    p2   <= '0;
                    k    <= k + CW'(1);
                    if (k == TOP) begin
                        msg_r <= d_r[k] ? p1 : res;
                        err_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign msg_out   = msg_r;
    assign err_out   = err_r;

endmodule

// File: tb/tb_rsa_modexp_decrypt.sv
// tb/tb_rsa_modexp_decrypt.sv - scoreboard bench for rsa_modexp_decrypt against an arithmetic modexp model
module tb_rsa_modexp_decrypt;

    localparam int W = 32;
    localparam int LAT_OK = 1 + W + W * (W + 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] n_in = '0, d_in = '0, c_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] msg_out;
    logic         err_out;
    logic         busy;

    typedef struct {
        logic [W-1:0] msg;
        logic         err;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   prev_ov = 0;

    rsa_modexp_decrypt #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .n_in(n_in), .d_in(d_in), .c_in(c_in), .out_valid(out_valid),
        .out_ready(out_ready), .msg_out(msg_out), .err_out(err_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Left-to-right binary exponentiation on 64-bit integers.
    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] n, input logic [W-1:0] d,
                                                 input logic [W-1:0] c);
        longint unsigned m, b, nn;
        nn = longint'(n);
        b  = longint'(c) % nn;
        m  = 1;
        for (int i = W - 1; i >= 0; i--) begin
            m = (m * m) % nn;
            if (d[i])
                m = (m * b) % nn;
        end
        return m[W-1:0];
    endfunction

    task automatic send(input logic [W-1:0] n, input logic [W-1:0] d, input logic [W-1:0] c);
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        n_in = n; d_in = d; c_in = c;
        while (!in_ready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        e.err = (n < 2);
        e.msg = e.err ? '0 : ref_modexp(n, d, c);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((sb.size() != 0 || !in_ready) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000)
            check("drain_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("msg_out", msg_out, e.msg);
                    check("err_out", err_out, e.err);
                    check("latency", cyc + 1 - e.acc, e.err ? 1 : LAT_OK);
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        logic [W-1:0] held;
        int guard;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_msg", msg_out, 0);
        check("rst_err", err_out, 0);
        rst_n = 1'b1;

        send(3233, 2753, 855);
        send(3233, 0, 855);
        send(3233, 1, 5000);
        send(1, 7, 9);
        send(0, 7, 9);
        send(2, 5, 7);
        send(2, 5, 8);
        send(3233, 3, 0);
        send(3233, 5, 6466);
        send(32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hFFFF_FFFE);
        drain();

        out_ready = 1'b0;
        send(3233, 2753, 855);
        guard = 0;
        while (!out_valid && guard < 1500) begin
            @(negedge clk);
            guard++;
        end
        check("hold_reached_done", out_valid, 1);
        held = msg_out;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 10) begin
                in_valid = 1'b1;
                n_in = 3233; d_in = 17; c_in = 65;
            end
            if (i == 11)
                in_valid = 1'b0;
            check("hold_valid", out_valid, 1);
            check("hold_msg", msg_out, held);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("post_hs_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        check("pulse_ignored_busy", busy, 0);

        send(3233, 2753, 855);
        repeat (500) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        send(3233, 2753, 855);
        drain();

        send(32'hFFFF_FFFF, $urandom, $urandom);
        for (int i = 0; i < 60; i++)
            send(32'hFFFF_FFFF - 2 * $urandom_range(0, 32'hFFFF), $urandom, $urandom);
        drain();
        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
